// File: rtl/reorder_buffer_pkg.sv
// Shared types and widths for the reorder buffer slice.
package reorder_buffer_pkg;

  localparam int unsigned REG_WIDTH         = 32;
  localparam int unsigned REG_ID_WIDTH      = 5;
  localparam int unsigned ROB_WIDTH_DEFAULT = 4;

  typedef struct packed {
    logic                    busy;
    logic                    ready;
    logic [REG_ID_WIDTH-1:0] rd;
    logic [REG_WIDTH-1:0]    value;
  } rob_entry_t;

endpackage

// File: rtl/rob_query_port.sv
// Combinational operand lookup by tag; ROB_WB_BYPASS_EN adds a same-cycle
// forward from the write-back bus.
module rob_query_port
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
  input  rob_entry_t           i_entries [1 << ROB_WIDTH],
  input  logic [ROB_WIDTH-1:0] i_query_tag,
  input  logic                 i_rdy,
  input  logic                 i_wb_signal,
  input  logic [ROB_WIDTH-1:0] i_wb_tag,
  input  logic [REG_WIDTH-1:0] i_wb_value,
  output logic                 o_ready,
  output logic [REG_WIDTH-1:0] o_value
);

  rob_entry_t w_sel;
  logic       w_hit_reg;

  assign w_sel     = i_entries[i_query_tag];
  assign w_hit_reg = w_sel.busy & w_sel.ready;

`ifdef ROB_WB_BYPASS_EN
  logic w_hit_wb;
  logic w_unused;

  assign w_hit_wb = i_rdy & i_wb_signal & w_sel.busy & (i_wb_tag == i_query_tag);
  assign w_unused = ^w_sel.rd;

  // The bus value is newer than anything held in the entry.
  always_comb begin
    o_ready = 1'b0;
    o_value = '0;
    if (w_hit_wb) begin
      o_ready = 1'b1;
      o_value = i_wb_value;
    end else if (w_hit_reg) begin
      o_ready = 1'b1;
      o_value = w_sel.value;
    end
  end
`else
  logic w_unused;

  assign w_unused = ^{w_sel.rd, i_rdy, i_wb_signal, i_wb_tag, i_wb_value};

  always_comb begin
    o_ready = 1'b0;
    o_value = '0;
    if (w_hit_reg) begin
      o_ready = 1'b1;
      o_value = w_sel.value;
    end
  end
`endif

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation, write-back capture, in-order commit
// and two operand queries. Optional macro: ROB_WB_BYPASS_EN.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    issue_signal,
  input  logic [REG_ID_WIDTH-1:0] issue_rd,
  output logic [ROB_WIDTH-1:0]    issue_tag,
  output logic                    rob_full,
  input  logic                    wb_signal,
  input  logic [ROB_WIDTH-1:0]    wb_tag,
  input  logic [REG_WIDTH-1:0]    wb_value,
  output logic                    commit_signal,
  output logic [REG_ID_WIDTH-1:0] commit_rd,
  output logic [ROB_WIDTH-1:0]    commit_rd_tag,
  output logic [REG_WIDTH-1:0]    commit_rd_value,
  input  logic [ROB_WIDTH-1:0]    query_tag_1,
  input  logic [ROB_WIDTH-1:0]    query_tag_2,
  output logic                    query_ready_1,
  output logic                    query_ready_2,
  output logic [REG_WIDTH-1:0]    query_value_1,
  output logic [REG_WIDTH-1:0]    query_value_2,
  input  logic                    flush_in
);

  localparam int unsigned DEPTH = 1 << ROB_WIDTH;

  rob_entry_t           r_entries [DEPTH];
  logic [ROB_WIDTH-1:0] r_head;
  logic [ROB_WIDTH-1:0] r_tail;
  logic [ROB_WIDTH:0]   r_count;

  rob_entry_t w_head_e;
  logic       w_full;
  logic       w_empty;
  logic       w_issue;
  logic       w_wb;
  logic       w_commit;

  assign w_head_e = r_entries[r_head];
  assign w_full   = (r_count == (ROB_WIDTH + 1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_issue  = rdy_in & issue_signal & ~w_full;
  assign w_wb     = rdy_in & wb_signal & r_entries[wb_tag].busy;
  assign w_commit = rdy_in & commit_signal;

  assign issue_tag     = r_tail;
  assign rob_full      = w_full;
  assign commit_rd     = w_head_e.rd;
  assign commit_rd_tag = r_head;

`ifdef ROB_WB_BYPASS_EN
  logic w_head_wb;

  assign w_head_wb       = w_wb & (wb_tag == r_head);
  assign commit_signal   = ~w_empty & w_head_e.busy & (w_head_e.ready | w_head_wb);
  assign commit_rd_value = w_head_wb ? wb_value : w_head_e.value;
`else
  assign commit_signal   = ~w_empty & w_head_e.busy & w_head_e.ready;
  assign commit_rd_value = w_head_e.value;
`endif

  // Commit is applied after write-back so a same-cycle retire of the written
  // entry leaves it cleared.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          r_entries[i].busy  <= 1'b0;
          r_entries[i].ready <= 1'b0;
        end
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_wb) begin
          r_entries[wb_tag].ready <= 1'b1;
          r_entries[wb_tag].value <= wb_value;
        end
        if (w_issue) begin
          r_entries[r_tail].busy  <= 1'b1;
          r_entries[r_tail].ready <= 1'b0;
          r_entries[r_tail].rd    <= issue_rd;
          r_tail                  <= r_tail + 1'b1;
        end
        if (w_commit) begin
          r_entries[r_head].busy  <= 1'b0;
          r_entries[r_head].ready <= 1'b0;
          r_head                  <= r_head + 1'b1;
        end
        case ({w_issue, w_commit})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query_1 (
    .i_entries   (r_entries),
    .i_query_tag (query_tag_1),
    .i_rdy       (rdy_in),
    .i_wb_signal (wb_signal),
    .i_wb_tag    (wb_tag),
    .i_wb_value  (wb_value),
    .o_ready     (query_ready_1),
    .o_value     (query_value_1)
  );

  rob_query_port #(.ROB_WIDTH(ROB_WIDTH)) u_query_2 (
    .i_entries   (r_entries),
    .i_query_tag (query_tag_2),
    .i_rdy       (rdy_in),
    .i_wb_signal (wb_signal),
    .i_wb_tag    (wb_tag),
    .i_wb_value  (wb_value),
    .o_ready     (query_ready_2),
    .o_value     (query_value_2)
  );

endmodule
